// File: rtl/verdict_collector.sv
// verdict_collector
//   Captures the active output streams of the monitor (A and B), tags each
//   record with a cycle timestamp, buffers them in a DEPTH-entry FIFO and
//   drains one record per cycle over a show-ahead valid/ready port.
//   Records that do not fit are counted (saturating) and flagged sticky.
//
// Ports
//   clk_i          clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   en_i           capture / timestamp enable
//   out_a_i/aktv_a_i, out_b_i/aktv_b_i   stream values and activity
//   rec_valid_o/rec_ready_i              drain handshake
//   rec_stream_o (0=A,1=B), rec_data_o, rec_time_o   head record
//   count_o        occupancy 0..DEPTH
//   overflow_o     sticky drop flag
//   drop_cnt_o     dropped records, saturating at 0xFFFF
module verdict_collector #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64,
    parameter int TS_W   = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic [DATA_W-1:0]        out_a_i,
    input  logic                     aktv_a_i,
    input  logic [DATA_W-1:0]        out_b_i,
    input  logic                     aktv_b_i,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output logic                     rec_stream_o,
    output logic [DATA_W-1:0]        rec_data_o,
    output logic [TS_W-1:0]          rec_time_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic              stream_q [DEPTH];
    logic [DATA_W-1:0] data_q   [DEPTH];
    logic [TS_W-1:0]   time_q   [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_b;
    logic [AW:0]   count_q, count_d, free;
    logic [TS_W-1:0] ts_q, ts_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [16:0]   drop_sum;
    logic          cap_a, cap_b, wr_a, wr_b, pop;
    logic [1:0]    n_act, n_wr, n_drop;

    always_comb begin
        // Free space uses the pre-edge count: a same-cycle pop does not
        // make room for this cycle's captures.
        free   = DEPTH_C - count_q;
        cap_a  = en_i & aktv_a_i;
        cap_b  = en_i & aktv_b_i;
        wr_a   = cap_a && (free != '0);
        // B needs one slot beyond whatever A consumed; if A was dropped
        // (free==0) this is also false, so A always precedes B.
        wr_b   = cap_b && (free > {{AW{1'b0}}, wr_a});
        n_act  = {1'b0, cap_a} + {1'b0, cap_b};
        n_wr   = {1'b0, wr_a} + {1'b0, wr_b};
        n_drop = n_act - n_wr;
        pop    = (count_q != '0) && rec_ready_i;

        wr_ptr_b   = wr_ptr_q + AW'(wr_a);
        wr_ptr_d   = wr_ptr_q + AW'(n_wr);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + (AW+1)'(n_wr) - (AW+1)'(pop);
        ts_d       = en_i ? ts_q + 1'b1 : ts_q;
        overflow_d = overflow_q | (n_drop != 2'd0);
        drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is cleared on reset so the show-ahead head reads zero while
    // the FIFO is freshly reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stream_q[i] <= 1'b0;
                data_q[i]   <= '0;
                time_q[i]   <= '0;
            end
        end else begin
            if (wr_a) begin
                stream_q[wr_ptr_q] <= 1'b0;
                data_q[wr_ptr_q]   <= out_a_i;
                time_q[wr_ptr_q]   <= ts_q;
            end
            if (wr_b) begin
                stream_q[wr_ptr_b] <= 1'b1;
                data_q[wr_ptr_b]   <= out_b_i;
                time_q[wr_ptr_b]   <= ts_q;
            end
        end
    end

    assign rec_valid_o  = (count_q != '0);
    assign rec_stream_o = stream_q[rd_ptr_q];
    assign rec_data_o   = data_q[rd_ptr_q];
    assign rec_time_o   = time_q[rd_ptr_q];
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: doc/verdict_collector.md
# verdict_collector

Downstream stage of the compiled RTLola monitor. Captures every cycle in which an output stream is active (`outA`/`aktvOutA`, `outB`/`aktvOutB`) and tags it with a cycle timestamp. Buffers the resulting records in a small FIFO and drains them one per cycle over a valid/ready port to the host/trace logic. Dropped records are counted, never silently lost.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `DATA_W`, 64: verdict width; signed, matches monitor outputs.
- `TS_W`, 32: timestamp width.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: capture/timestamp enable; same signal that enables the monitor.
- `out_a` in DATA_W: stream A value.
- `aktv_a` in 1: stream A produced a value this cycle.
- `out_b` in DATA_W: stream B value.
- `aktv_b` in 1: stream B produced a value this cycle.
- `rec_valid` out 1: record available at FIFO head.
- `rec_ready` in 1: consumer accepts head record.
- `rec_stream` out 1: 0 = A, 1 = B.
- `rec_data` out DATA_W: verdict value.
- `rec_time` out TS_W: timestamp of capture cycle.
- `count` out log2(DEPTH)+1: occupancy.
- `overflow` out 1: sticky; set on first drop.
- `drop_cnt` out 16: dropped records; saturates at 0xFFFF.

## Operation
- Timestamp counter `ts`: increments by 1 each cycle with `en`=1; holds when `en`=0; wraps modulo 2^TS_W.
- Capture, only when `en`=1: each active stream produces one record {stream, data, ts}, where `ts` is the value before this edge's increment.
- Both active in the same cycle: A is written at `wr_ptr`, then B at `wr_ptr+1`. Order is always A before B.
- Free space = DEPTH − `count` sampled before the edge. A same-cycle pop does not free space for same-cycle writes.
- Insufficient space:
  - Free = 1 with both streams active: A is stored, B is dropped.
  - Free = 0: all active records are dropped.
  - `drop_cnt` increases by the number dropped (0/1/2), saturating at 0xFFFF.
  - `overflow` is set and held until reset.
- Drain is show-ahead:
  - `rec_valid` = (`count` ≠ 0).
  - `rec_*` always reflect the entry at `rd_ptr`.
  - A pop occurs when `rec_valid`·`rec_ready`.
  - `rec_ready` while empty has no effect.
- Drain is independent of `en`.
- `count` next = `count` + writes − pop; range 0..DEPTH. Pointers are log2(DEPTH) bits and wrap.
- `aktv_*` while `en`=0 is ignored: not captured, not counted as dropped.

## Timing
- Reset (async assert, synchronous-safe release): `ts`=0, pointers=0, `count`=0, `rec_valid`=0, `rec_stream`=0, `rec_data`=0, `rec_time`=0, `overflow`=0, `drop_cnt`=0. Memory contents are don't-care.
- Reset mid-operation discards all buffered records immediately; outputs follow reset values while `rst`=0.
- Latency: a verdict active in cycle k appears on `rec_valid`/`rec_*` in cycle k+1 when the FIFO was empty.
- Throughput: 1 record out per cycle. Up to 2 in per cycle, so sustained dual activity overflows unless drained.
- Push and pop in the same cycle at `count`=DEPTH: the pop succeeds, pushes are dropped, and next `count`=DEPTH−1.
- Push and pop in the same cycle at `count`=1: the head advances to the new record; `rec_valid` stays 1.
- `rec_*` are stable while `rec_valid`=1 and `rec_ready`=0.

## Test plan
- Single capture: reset, 5 idle cycles with `en`=0, then `en`=1 with `aktv_a` pulse, `out_a`=5 in the first enabled cycle → next cycle `rec_valid`=1, `rec_stream`=0, `rec_data`=5, `rec_time`=0. Pop with `rec_ready` → `count`=0.
- Simultaneous A/B: `aktv_a`=`aktv_b`=1, `out_a`=15, `out_b`=−3 at `ts`=7 → two records in order {0,15,7} then {1,−3,7}; `count`=2.
- Overflow: `rec_ready`=0, dual activity for 5 cycles with DEPTH=8 → after 4 cycles `count`=8; cycle 5 gives `drop_cnt`=2, `overflow`=1. A single-A cycle at `count`=7 with B also active → A kept, `drop_cnt`+1.
- Full with simultaneous pop: `count`=8, `rec_ready`=1, `aktv_a`=1 → A dropped, `count`=7, head advances, `drop_cnt`+1.
- Enable gating: `en`=0 with `aktv_a`=1 for 10 cycles → no records, `ts` frozen, `drop_cnt` unchanged; drain of existing records continues.
- Reset mid-operation: 3 records buffered, `overflow`=1, assert `rst`=0 asynchronously mid-cycle → `rec_valid`, `count`, `overflow`, `drop_cnt`, `ts` at 0 without a clock edge. After release, the next capture has `rec_time`=0.
